// File: rtl/stage_2_scheduler_if.sv
// Symbol-in / bundle-out handshake between the symbol source, the Stage 2 scheduler and Stage 2.
// The scheduler uses the slave view; the environment that feeds and drains it uses the master view.
interface stage_2_scheduler_if #(
  parameter int SYMBOL_WIDTH  = 4,
  parameter int PAYLOAD_WIDTH = 65
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_bool;
  logic [SYMBOL_WIDTH-1:0]  in_symbol;
  logic [PAYLOAD_WIDTH-1:0] in_payload;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_bool_flag_1;
  logic                     out_bool_flag_2;
  logic                     out_bool_flag_3;
  logic                     out_bool_flag_4;
  logic [SYMBOL_WIDTH-1:0]  out_symbol_1;
  logic [SYMBOL_WIDTH-1:0]  out_symbol_2;
  logic [SYMBOL_WIDTH-1:0]  out_symbol_3;
  logic [SYMBOL_WIDTH-1:0]  out_symbol_4;
  logic [PAYLOAD_WIDTH-1:0] out_payload;

  modport slave (
    input  in_valid, in_bool, in_symbol, in_payload, flush, out_ready,
    output in_ready, out_valid, out_bool_flag_1, out_bool_flag_2, out_bool_flag_3,
           out_bool_flag_4, out_symbol_1, out_symbol_2, out_symbol_3, out_symbol_4, out_payload
  );

  modport master (
    output in_valid, in_bool, in_symbol, in_payload, flush, out_ready,
    input  in_ready, out_valid, out_bool_flag_1, out_bool_flag_2, out_bool_flag_3,
           out_bool_flag_4, out_symbol_1, out_symbol_2, out_symbol_3, out_symbol_4, out_payload
  );
endinterface

// File: rtl/stage_2_scheduler.sv
// Packs boolean symbols into bundles of up to four lanes for Stage 2; CDF symbols go out alone.
// Optional idle-timeout issue of partial bundles is enabled with the macro S2_SCHED_TIMEOUT_EN.
module stage_2_scheduler #(
  parameter int SYMBOL_WIDTH  = 4,
  parameter int PAYLOAD_WIDTH = 65,
  parameter int MAX_WAIT      = 8
) (
  input  logic               clk,
  input  logic               reset,
  stage_2_scheduler_if.slave bus,
  output logic               busy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} state_t;
  state_t state, state_nxt;

  logic [SYMBOL_WIDTH-1:0]  acc_sym_p0 [1:3];
  logic                     vld_p1;
  logic [4:1]               flag_p1;
  logic [SYMBOL_WIDTH-1:0]  sym_p1 [1:4];
  logic [PAYLOAD_WIDTH-1:0] pay_p1;

  logic                     out_free, in_ready, in_xfer, bool_acc, cdf_acc;
  logic                     cdf_pending, timeout_hit, bool_issue, issue;
  logic [2:0]               n;
  logic [4:1]               flag_nxt;
  logic [SYMBOL_WIDTH-1:0]  sym_nxt [1:4];
  logic [PAYLOAD_WIDTH-1:0] pay_nxt;

  // Legal MAX_WAIT is 1..255; an out-of-range value shows up as this block in the hierarchy.
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_illegal_max_wait
  end

  always_comb begin
    out_free    = !vld_p1 || bus.out_ready;
    in_ready    = out_free && (bus.in_bool || state == EMPTY);
    in_xfer     = bus.in_valid && in_ready;
    bool_acc    = in_xfer && bus.in_bool;
    cdf_acc     = in_xfer && !bus.in_bool;
    n           = {1'b0, state} + {2'b00, bool_acc};
    // A waiting CDF forces the pending booleans out first so bundle order matches arrival order.
    cdf_pending = bus.in_valid && !bus.in_bool && (state != EMPTY);
    bool_issue  = out_free && ((n == 3'd4) || (bus.flush && n != 3'd0) || cdf_pending || timeout_hit);
    issue       = bool_issue || cdf_acc;
    state_nxt   = state;
    if (bool_issue)    state_nxt = EMPTY;
    else if (bool_acc) state_nxt = state_t'(state + 2'd1);
  end

  always_comb begin
    flag_nxt = '0;
    pay_nxt  = '0;
    for (int k = 1; k <= 4; k++) sym_nxt[k] = '0;
    if (cdf_acc) begin
      sym_nxt[1] = bus.in_symbol;
      pay_nxt    = bus.in_payload;
    end else begin
      for (int k = 1; k <= 4; k++) flag_nxt[k] = (k <= int'(n));
      for (int k = 1; k <= 3; k++)
        if (k <= int'(state)) sym_nxt[k] = acc_sym_p0[k];
      for (int k = 1; k <= 4; k++)
        if (bool_acc && k == int'(n)) sym_nxt[k] = bus.in_symbol;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // p0: accumulator lanes; only lanes 1..count are ever read, so they need no reset.
  always_ff @(posedge clk) begin
    if (bool_acc && !bool_issue) begin
      case (state)
        EMPTY:   acc_sym_p0[1] <= bus.in_symbol;
        B1:      acc_sym_p0[2] <= bus.in_symbol;
        B2:      acc_sym_p0[3] <= bus.in_symbol;
        default: ;
      endcase
    end
  end

  // p1: bundle register driving Stage 2; holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      flag_p1 <= '0;
      pay_p1  <= '0;
      for (int k = 1; k <= 4; k++) sym_p1[k] <= '0;
    end else if (issue) begin
      vld_p1  <= 1'b1;
      flag_p1 <= flag_nxt;
      sym_p1  <= sym_nxt;
      pay_p1  <= pay_nxt;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef S2_SCHED_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  logic [7:0] wait_q;

  // Keeps counting past the limit while stalled so the issue fires on the first free cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     wait_q <= 8'd0;
    else if (in_xfer || issue)                     wait_q <= 8'd0;
    else if (state != EMPTY && wait_q != 8'hFF)    wait_q <= wait_q + 8'd1;
  end

  assign timeout_hit = (state != EMPTY) && (wait_q >= WAIT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = vld_p1;
  assign bus.out_bool_flag_1 = flag_p1[1];
  assign bus.out_bool_flag_2 = flag_p1[2];
  assign bus.out_bool_flag_3 = flag_p1[3];
  assign bus.out_bool_flag_4 = flag_p1[4];
  assign bus.out_symbol_1    = sym_p1[1];
  assign bus.out_symbol_2    = sym_p1[2];
  assign bus.out_symbol_3    = sym_p1[3];
  assign bus.out_symbol_4    = sym_p1[4];
  assign bus.out_payload     = pay_p1;
  assign busy                = (state != EMPTY) || vld_p1;
endmodule

// File: doc/stage_2_scheduler.md
# stage_2_scheduler

Input scheduler placed directly in front of Stage 2 of the 4-boolean entropy encoder. It accepts one symbol per cycle over a valid/ready handshake. Consecutive boolean symbols are packed into bundles of up to four, matching the four chained boolean lanes. Each CDF (non-boolean) symbol is issued as a bundle of its own. Bundles are held in a single output register that drives bool_flag_1..4, symbol_1..4 and the CDF operand payload of Stage 2.

## Interface
Parameters:
- SYMBOL_WIDTH, 4, width of each symbol field.
- PAYLOAD_WIDTH, 65, width of the CDF operand payload {UU, VV, lut_u, lut_v, COMP_mux_1}. It is passed through opaque.
- MAX_WAIT, 8, idle cycles a partial boolean bundle may wait before forced issue. Range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  scheduler accepts the input symbol this cycle.
- in_bool  in  1  1 = boolean symbol, 0 = CDF symbol.
- in_symbol  in  SYMBOL_WIDTH  symbol value.
- in_payload  in  PAYLOAD_WIDTH  CDF operands. Ignored when in_bool=1.
- flush  in  1  level signal, end of frame: issue any partial bundle.
- out_valid  out  1  bundle register holds a valid bundle.
- out_ready  in  1  Stage 2 consumes the bundle this cycle.
- out_bool_flag_1..4  out  1 each  lane-valid flags for the boolean lanes.
- out_symbol_1..4  out  SYMBOL_WIDTH each  lane symbols.
- out_payload  out  PAYLOAD_WIDTH  CDF operands.
- busy  out  1  high when count != 0 or out_valid = 1.

## Operation
Transfers:
- An input transfer occurs when in_valid & in_ready.
- An output transfer occurs when out_valid & out_ready.
- out_free = !out_valid | out_ready.

Accumulator:
- Holds count (0..3) pending boolean symbols in lanes 1..count. This count is the state: EMPTY(0), B1, B2, B3.
- in_ready = out_free & (in_bool | count == 0).
- A CDF symbol is never accepted while booleans are pending.

Boolean accept:
- The symbol goes into lane count+1.
- n = count + 1.

Bundle issue (loads the bundle register; out_valid=1 next cycle). Define n = count + (boolean accepted this cycle). A bundle issues when out_free and any of the following holds:
- n == 4;
- flush & n > 0;
- in_valid & !in_bool & count > 0 (CDF pending: drain the booleans first, CDF not accepted this cycle);
- timeout (see Configuration).

Bundle register contents:
- Boolean bundle: bool_flag_k = 1 for k ≤ n, else 0. symbol_k holds the lanes, with 0 in unused lanes. payload = 0. After issue, count returns to 0.
- CDF bundle (accepted with count == 0): all bool flags 0, symbol_1 = in_symbol, symbols 2..4 = 0, payload = in_payload.

Flag and ordering rules:
- Flags are always contiguous from lane 1.
- Lane order equals arrival order.
- Bundles issue in arrival order. A boolean run is never split around a CDF symbol except at multiples of 4.

Other behaviour:
- Output transfer with no new issue: out_valid drops to 0.
- Output transfer together with a new issue: back-to-back, out_valid stays 1.
- flush with count == 0 and no boolean accept: no effect.

## Timing
- Reset (asynchronous): out_valid=0, all bundle outputs 0, count=0, wait counter 0, busy=0. in_ready is 1 when reset deasserts.
- Latency: a bundle is visible on the outputs 1 cycle after the cycle that completes it.
- Throughput:
  - 1 boolean symbol per cycle, 1 bundle per 4 booleans.
  - 1 CDF per cycle when count == 0.
  - A CDF arriving with count > 0 costs 1 extra cycle (drain).
- Backpressure: when out_ready=0 and out_valid=1, in_ready=0. The bundle register and accumulator hold, and out_* stay stable.
- Reset mid-operation discards pending symbols and the bundle register with no output.

## Configuration
- Macro S2_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter increments each cycle with count > 0 and no input transfer.
  - It clears on any input transfer or bundle issue.
  - When it reaches MAX_WAIT and out_free, the partial bundle issues. If the register is not free, issue happens on the first out_free cycle.
- Undefined: the wait counter is not synthesized. Partial bundles issue only on a CDF arrival or on flush.

## Test plan
- Reset, then 4 booleans with symbols 1,0,1,1 on consecutive cycles, out_ready=1 → one bundle with flags 1111 and symbol[0] bits 1,0,1,1 one cycle after the 4th accept; in_ready stays 1.
- Booleans 1,1 then a CDF with payload 0x1_ABCD_1234_0040_0010 → bundle with flags 1100, in_ready=0 for exactly one cycle, then a CDF bundle with flags 0000 and the payload intact.
- 6 booleans followed by flush held for 1 cycle → bundle 1111, then bundle 1100; busy falls to 0 after the final output transfer.
- With S2_SCHED_TIMEOUT_EN and MAX_WAIT=8: 1 boolean, then idle → bundle 1000 issues after 8 idle cycles. Without the macro: no issue within 50 cycles.
- out_ready=0 for 10 cycles while the register is full → out_* stable, in_ready=0, no symbol lost. Asserting reset mid-stall → out_valid=0 and busy=0 immediately.
